// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state type and default sizes for the fetch stage
package fetch_pkg;

    localparam int FETCH_AW          = 8;
    localparam int FETCH_IW          = 16;
    localparam int FETCH_TIMEOUT_CYC = 15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DRAIN,
        S_HOLD,
        S_ERR
    } fetch_state_t;

endpackage

// File: rtl/fetch_watchdog.sv
// rtl/fetch_watchdog.sv - counts consecutive un-acked memory-wait cycles
module fetch_watchdog
    import fetch_pkg::*;
#(
    parameter int TIMEOUT_CYC = FETCH_TIMEOUT_CYC
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] count;

    // Saturates once expired so a held-off expiry keeps reporting.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || !run) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = run && !clear && (count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - multicycle instruction fetch stage driving the PC register
// Optional memory-wait timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int AW          = FETCH_AW,
    parameter int IW          = FETCH_IW,
    parameter int TIMEOUT_CYC = FETCH_TIMEOUT_CYC
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] pc_atual,
    output logic [AW-1:0] pc_proximo,
    output logic          esc_pc,
    output logic [AW-1:0] mem_addr,
    output logic          mem_req,
    input  logic          mem_ack,
    input  logic [IW-1:0] mem_rdata,
    output logic [IW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    input  logic          halt,
    output logic          fetch_err
);

    fetch_state_t state;

`ifdef FETCH_TIMEOUT_EN
    logic wd_run;
    logic timed_out;
    logic err_q;

    assign wd_run    = (state == S_WAIT) || (state == S_DRAIN);
    assign fetch_err = err_q;

    fetch_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .run    (wd_run),
        .clear  (mem_ack),
        .expired(timed_out)
    );
`else
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            esc_pc      <= 1'b0;
            pc_proximo  <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
        end else begin
            esc_pc <= 1'b0;
            // A taken branch owns the PC write in every live state.
            if (redirect && state != S_ERR) begin
                esc_pc     <= 1'b1;
                pc_proximo <= redirect_pc;
            end

            case (state)
                S_IDLE: begin
                    // esc_pc low means the PC register already holds its new value.
                    if (!redirect && !halt && !esc_pc) begin
                        mem_addr <= pc_atual;
                        mem_req  <= 1'b1;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        if (mem_ack) begin
                            mem_req <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end else if (mem_ack) begin
                        instr       <= mem_rdata;
                        instr_pc    <= mem_addr;
                        instr_valid <= 1'b1;
                        esc_pc      <= 1'b1;
                        pc_proximo  <= mem_addr + AW'(1);
                        mem_req     <= 1'b0;
                        state       <= S_HOLD;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (timed_out) begin
                        mem_req <= 1'b0;
                        err_q   <= 1'b1;
                        state   <= S_ERR;
                    end
`endif
                end
                S_DRAIN: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= S_IDLE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (timed_out && !redirect) begin
                        mem_req <= 1'b0;
                        err_q   <= 1'b1;
                        state   <= S_ERR;
                    end
`endif
                end
                S_HOLD: begin
                    if (redirect || instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
`ifdef FETCH_TIMEOUT_EN
                S_ERR: begin
                    state <= S_ERR;
                end
`endif
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a PC register and memory model
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  pc_atual;
    logic [7:0]  pc_proximo;
    logic        esc_pc;
    logic [7:0]  mem_addr;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic        halt = 1'b0;
    logic        fetch_err;

    logic [7:0]  pc_reg = '0;
    logic [15:0] mem_model [256];
    int          n_cmp = 0;
    int          n_err = 0;

    assign pc_atual = pc_reg;

    always #5 clock = ~clock;

    fetch_unit dut (
        .clock      (clock),
        .reset      (reset),
        .pc_atual   (pc_atual),
        .pc_proximo (pc_proximo),
        .esc_pc     (esc_pc),
        .mem_addr   (mem_addr),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .fetch_err  (fetch_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; the PC register loads pc_proximo whenever esc_pc is seen.
    task automatic step();
        @(posedge clock);
        #1;
        if (esc_pc === 1'b1) pc_reg = pc_proximo;
    endtask

    // mode: 0 plain, 1 redirect during wait, 2 redirect with ack,
    //       3 redirect at hold handshake, 4 redirect while idle before fetch
    task automatic fetch_one(input int mode, input int delay, input logic [7:0] rpc, input int rdly);
        logic [7:0] a;
        logic [7:0] a_next;
        int k;
        if (mode == 4) begin
            redirect = 1'b1; redirect_pc = rpc;
            step();
            redirect = 1'b0;
            check("idle_redir_esc", esc_pc, 1);
            check("idle_redir_pc", pc_proximo, rpc);
            check("idle_redir_noreq", mem_req, 0);
        end
        k = 0;
        while (mem_req !== 1'b1 && k < 10) begin
            step();
            k++;
        end
        check("req_seen", mem_req, 1);
        check("req_addr", mem_addr, pc_reg);
        a = pc_reg;
        a_next = a + 8'd1;
        for (int i = 0; i < delay; i++) begin
            if (mode == 1 && i == 0) begin
                redirect = 1'b1; redirect_pc = rpc;
            end
            step();
            redirect = 1'b0;
            if (mode == 1 && i == 0) begin
                check("wait_redir_esc", esc_pc, 1);
                check("wait_redir_pc", pc_proximo, rpc);
            end else begin
                check("wait_no_esc", esc_pc, 0);
            end
            check("wait_req_held", mem_req, 1);
            check("wait_addr_held", mem_addr, a);
        end
        mem_ack = 1'b1;
        mem_rdata = mem_model[a];
        if (mode == 2) begin
            redirect = 1'b1; redirect_pc = rpc;
        end
        step();
        mem_ack = 1'b0;
        redirect = 1'b0;
        mem_rdata = 16'($urandom);
        check("ack_req_drop", mem_req, 0);
        if (mode == 1) begin
            check("drain_no_valid", instr_valid, 0);
            check("drain_no_esc", esc_pc, 0);
        end else if (mode == 2) begin
            check("ackredir_no_valid", instr_valid, 0);
            check("ackredir_esc", esc_pc, 1);
            check("ackredir_pc", pc_proximo, rpc);
        end else begin
            check("ack_valid", instr_valid, 1);
            check("ack_instr", instr, mem_model[a]);
            check("ack_instr_pc", instr_pc, a);
            check("ack_esc", esc_pc, 1);
            check("ack_pc_next", pc_proximo, a_next);
            for (int i = 0; i < rdly; i++) begin
                step();
                check("hold_valid", instr_valid, 1);
                check("hold_instr", instr, mem_model[a]);
                check("hold_instr_pc", instr_pc, a);
                check("hold_no_req", mem_req, 0);
                check("hold_no_esc", esc_pc, 0);
            end
            instr_ready = 1'b1;
            if (mode == 3) begin
                redirect = 1'b1; redirect_pc = rpc;
            end
            step();
            instr_ready = 1'b0;
            redirect = 1'b0;
            check("handshake_clear", instr_valid, 0);
            if (mode == 3) begin
                check("holdredir_esc", esc_pc, 1);
                check("holdredir_pc", pc_proximo, rpc);
            end else begin
                check("handshake_no_esc", esc_pc, 0);
            end
        end
    endtask

    initial begin
        int mode;
        int dly;
        for (int i = 0; i < 256; i++) mem_model[i] = 16'($urandom);
        mem_model[0] = 16'hA55A;

        // Reset state
        step();
        step();
        check("rst_mem_req", mem_req, 0);
        check("rst_esc_pc", esc_pc, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_pc_next", pc_proximo, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_fetch_err", fetch_err, 0);
        reset = 1'b1;

        // Basic fetch of 0x00 with backpressure, then the follow-on fetch of 0x01
        fetch_one(0, 2, 8'h00, 5);
        check("next_pc_after_first", pc_reg, 8'h01);
        fetch_one(0, 1, 8'h00, 0);

        // Wrap-around
        pc_reg = 8'hFF;
        fetch_one(0, 0, 8'h00, 1);
        check("wrap_pc", pc_reg, 8'h00);

        // Redirect during wait, then fetch of the target
        mem_model[0] = 16'h1234;
        fetch_one(1, 3, 8'h40, 0);
        check("redir_target_pc", pc_reg, 8'h40);
        fetch_one(0, 1, 8'h00, 0);

        // Redirect coincident with ack, then with hold handshake
        fetch_one(2, 1, 8'h80, 0);
        step();
        check("ackredir_single_esc", esc_pc, 0);
        fetch_one(3, 0, 8'h10, 2);
        step();
        check("holdredir_single_esc", esc_pc, 0);
        fetch_one(4, 1, 8'h22, 1);

        // Randomized sequence
        for (int n = 0; n < 30; n++) begin
            mode = $urandom_range(0, 4);
            dly = $urandom_range(0, 4);
            if (mode == 1 && dly == 0) dly = 1;
            if ($urandom_range(0, 3) == 0 && esc_pc === 1'b0) pc_reg = 8'($urandom);
            fetch_one(mode, dly, 8'($urandom), $urandom_range(0, 3));
        end

        // Asynchronous reset mid-wait, then halt
        begin
            int k = 0;
            while (mem_req !== 1'b1 && k < 10) begin
                step();
                k++;
            end
            check("pre_reset_req", mem_req, 1);
            reset = 1'b0;
            pc_reg = 8'h00;
            halt = 1'b1;
            #1;
            check("async_reset_req", mem_req, 0);
            check("async_reset_valid", instr_valid, 0);
            step();
            reset = 1'b1;
            for (int i = 0; i < 4; i++) begin
                step();
                check("halt_no_req", mem_req, 0);
            end
            halt = 1'b0;
            fetch_one(0, 1, 8'h00, 0);
        end

        // Memory-wait timeout
        begin
            int k = 0;
            while (mem_req !== 1'b1 && k < 10) begin
                step();
                k++;
            end
            check("to_req_seen", mem_req, 1);
`ifdef FETCH_TIMEOUT_EN
            for (int i = 0; i < 14; i++) step();
            check("to_before_req", mem_req, 1);
            check("to_before_err", fetch_err, 0);
            step();
            check("to_req_drop", mem_req, 0);
            check("to_err_set", fetch_err, 1);
            redirect = 1'b1; redirect_pc = 8'h55;
            step();
            redirect = 1'b0;
            check("to_redir_ignored", esc_pc, 0);
            for (int i = 0; i < 3; i++) step();
            check("to_err_sticky", fetch_err, 1);
            check("to_err_no_req", mem_req, 0);
            reset = 1'b0;
            #1;
            check("to_err_reset", fetch_err, 0);
            step();
            reset = 1'b1;
`else
            for (int i = 0; i < 20; i++) step();
            check("nto_req_held", mem_req, 1);
            check("nto_no_err", fetch_err, 0);
            mem_ack = 1'b1;
            mem_rdata = mem_model[mem_addr];
            step();
            mem_ack = 1'b0;
            check("nto_valid", instr_valid, 1);
            check("nto_no_err_after", fetch_err, 0);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
